// File: rtl/ex_issue_ctrl.sv
// Issue controller between decode and ex: a register scoreboard guards RAW/WAW hazards,
// an in-flight cap limits outstanding operations, and control transfers are serialised.
module ex_issue_ctrl #(
    parameter int XCNT         = 32,
    parameter int XLEN         = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    DEC_VALID,
    output logic                    DEC_READY,
    input  logic [$clog2(XCNT)-1:0] DEC_RS1,
    input  logic [$clog2(XCNT)-1:0] DEC_RS2,
    input  logic [$clog2(XCNT)-1:0] DEC_RD,
    input  logic                    DEC_USE_RS1,
    input  logic                    DEC_USE_RS2,
    input  logic                    DEC_RD_WE,
    input  logic                    DEC_JAL,
    input  logic                    DEC_JALR,
    input  logic                    DEC_BRANCH,
    input  logic [XLEN-1:0]         DEC_PC,
    output logic                    EXECUTE_ENABLED,
    output logic [XLEN-1:0]         ISSUE_PC,
    input  logic                    WB_VALID,
    input  logic [$clog2(XCNT)-1:0] WB_RD,
    input  logic                    RESOLVE_VALID,
    input  logic                    RESOLVE_TAKEN,
    output logic                    FLUSH,
    output logic                    EXECUTE_HAZARD
);

    localparam int RW = $clog2(XCNT);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [XCNT-1:0] ONE  = XCNT'(1);
    localparam logic [CW-1:0]   MAXC = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0]   INC  = CW'(1);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_RES,
        S_FLUSH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XCNT-1:0] r_sb;
    logic [XCNT-1:0] w_clr;
    logic [XCNT-1:0] w_set;
    logic [XCNT-1:0] w_busy;
    logic [XCNT-1:0] w_sb_nxt;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   w_infl_eff;
    logic            w_wb_dec;
    logic            w_raw;
    logic            w_waw;
    logic            w_full;
    logic            w_issue;
    logic            w_ctrl;
    logic            r_ex_en;
    logic [XLEN-1:0] r_issue_pc;

    // Same-cycle writeback releases the register; ex forwards the result.
    assign w_clr  = (WB_VALID && WB_RD != '0) ? (ONE << WB_RD) : '0;
    assign w_busy = r_sb & ~w_clr;

    assign w_raw = (DEC_USE_RS1 && DEC_RS1 != '0 && w_busy[DEC_RS1])
                || (DEC_USE_RS2 && DEC_RS2 != '0 && w_busy[DEC_RS2]);
    assign w_waw = DEC_RD_WE && DEC_RD != '0 && w_busy[DEC_RD];

    // A writeback with nothing in flight is dropped so the counter cannot wrap.
    assign w_wb_dec   = WB_VALID && (r_inflight != '0);
    assign w_infl_eff = w_wb_dec ? (r_inflight - INC) : r_inflight;
    assign w_full     = (w_infl_eff == MAXC);

    assign w_ctrl  = DEC_JAL || DEC_JALR || DEC_BRANCH;
    assign w_issue = DEC_VALID && DEC_READY;

    assign w_set = (w_issue && DEC_RD_WE && DEC_RD != '0)
                 ? (ONE << DEC_RD) : '0;

    always_comb begin
        w_sb_nxt    = (r_sb & ~w_clr) | w_set;
        w_sb_nxt[0] = 1'b0;
    end

    always_comb begin
        w_state_nxt    = r_state;
        DEC_READY      = 1'b0;
        FLUSH          = 1'b0;
        EXECUTE_HAZARD = 1'b0;
        unique case (r_state)
            S_RUN: begin
                DEC_READY = !w_raw && !w_waw && !w_full;
                if (DEC_VALID && DEC_READY && w_ctrl)
                    w_state_nxt = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (RESOLVE_VALID)
                    w_state_nxt = RESOLVE_TAKEN ? S_FLUSH : S_RUN;
            end
            S_FLUSH: begin
                FLUSH       = 1'b1;
                w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
        EXECUTE_HAZARD = DEC_VALID && !DEC_READY;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state    <= S_RUN;
            r_sb       <= '0;
            r_inflight <= '0;
            r_ex_en    <= 1'b0;
            r_issue_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sb    <= w_sb_nxt;
            r_ex_en <= w_issue;
            if (w_issue)
                r_issue_pc <= DEC_PC;
            if (w_issue && !w_wb_dec)
                r_inflight <= r_inflight + INC;
            else if (!w_issue && w_wb_dec)
                r_inflight <= r_inflight - INC;
        end
    end

    assign EXECUTE_ENABLED = r_ex_en;
    assign ISSUE_PC        = r_issue_pc;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl: hazards, in-flight cap, branch
// serialisation, flush and mid-transfer reset, checked against hand values.
module tb_ex_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        DEC_VALID;
    logic        DEC_READY;
    logic [4:0]  DEC_RS1, DEC_RS2, DEC_RD;
    logic        DEC_USE_RS1, DEC_USE_RS2, DEC_RD_WE;
    logic        DEC_JAL, DEC_JALR, DEC_BRANCH;
    logic [31:0] DEC_PC;
    logic        EXECUTE_ENABLED;
    logic [31:0] ISSUE_PC;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic        RESOLVE_VALID, RESOLVE_TAKEN;
    logic        FLUSH;
    logic        EXECUTE_HAZARD;

    int n_chk  = 0;
    int n_pass = 0;

    ex_issue_ctrl dut (
        .CLK(CLK), .RSTN(RSTN),
        .DEC_VALID(DEC_VALID), .DEC_READY(DEC_READY),
        .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2), .DEC_RD(DEC_RD),
        .DEC_USE_RS1(DEC_USE_RS1), .DEC_USE_RS2(DEC_USE_RS2),
        .DEC_RD_WE(DEC_RD_WE),
        .DEC_JAL(DEC_JAL), .DEC_JALR(DEC_JALR), .DEC_BRANCH(DEC_BRANCH),
        .DEC_PC(DEC_PC),
        .EXECUTE_ENABLED(EXECUTE_ENABLED), .ISSUE_PC(ISSUE_PC),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD),
        .RESOLVE_VALID(RESOLVE_VALID), .RESOLVE_TAKEN(RESOLVE_TAKEN),
        .FLUSH(FLUSH), .EXECUTE_HAZARD(EXECUTE_HAZARD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs1, rs2, rd,
                       input logic u1, u2, we, br, input logic [31:0] pc);
        DEC_VALID   = v;
        DEC_RS1     = rs1;
        DEC_RS2     = rs2;
        DEC_RD      = rd;
        DEC_USE_RS1 = u1;
        DEC_USE_RS2 = u2;
        DEC_RD_WE   = we;
        DEC_JAL     = 1'b0;
        DEC_JALR    = 1'b0;
        DEC_BRANCH  = br;
        DEC_PC      = pc;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        WB_VALID = v;
        WB_RD    = rd;
    endtask

    initial begin
        RSTN = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        RESOLVE_VALID = 1'b0;
        RESOLVE_TAKEN = 1'b0;
        step;
        step;
        chk("rst_ee", 32'(EXECUTE_ENABLED), 0);
        chk("rst_flush", 32'(FLUSH), 0);
        chk("rst_pc", ISSUE_PC, 0);
        RSTN = 1'b1;

        // RAW on x5, released by same-cycle writeback
        drv(1, 0, 0, 5, 0, 0, 1, 0, 32'h10);
        #1 chk("raw_rdy0", 32'(DEC_READY), 1);
        step;
        chk("raw_ee0", 32'(EXECUTE_ENABLED), 1);
        chk("raw_pc0", ISSUE_PC, 32'h10);
        drv(1, 5, 0, 6, 1, 0, 1, 0, 32'h14);
        #1 chk("raw_haz", 32'(EXECUTE_HAZARD), 1);
        chk("raw_rdy1", 32'(DEC_READY), 0);
        step;
        chk("raw_ee_stall", 32'(EXECUTE_ENABLED), 0);
        wb(1, 5);
        #1 chk("raw_wb_rdy", 32'(DEC_READY), 1);
        step;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(1, 6);
        chk("raw_ee1", 32'(EXECUTE_ENABLED), 1);
        chk("raw_pc1", ISSUE_PC, 32'h14);
        step;
        wb(0, 0);

        // three rd=0 writers back to back
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 0, 0, 1, 1, 1, 0, 32'h20 + 32'(4 * i));
            #1 chk("x0_haz", 32'(EXECUTE_HAZARD), 0);
            step;
            chk("x0_ee", 32'(EXECUTE_ENABLED), 1);
            chk("x0_pc", ISSUE_PC, 32'h20 + 32'(4 * i));
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(1, 0);
        step;
        chk("x0_ee_end", 32'(EXECUTE_ENABLED), 0);
        step;
        step;
        wb(0, 0);

        // in-flight cap: four issue, fifth waits for a writeback
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 5'(i + 1), 0, 0, 1, 0, 32'h40 + 32'(4 * i));
            #1 chk("cap_rdy", 32'(DEC_READY), 1);
            step;
        end
        drv(1, 0, 0, 5, 0, 0, 1, 0, 32'h50);
        #1 chk("cap_full", 32'(DEC_READY), 0);
        chk("cap_haz", 32'(EXECUTE_HAZARD), 1);
        step;
        chk("cap_ee_stall", 32'(EXECUTE_ENABLED), 0);
        wb(1, 1);
        #1 chk("cap_wb_rdy", 32'(DEC_READY), 1);
        step;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("cap_ee", 32'(EXECUTE_ENABLED), 1);
        chk("cap_pc", ISSUE_PC, 32'h50);
        for (int r = 2; r <= 5; r++) begin
            wb(1, 5'(r));
            step;
        end
        wb(0, 0);

        // branch not taken
        drv(1, 0, 0, 0, 0, 0, 0, 1, 32'h100);
        step;
        chk("bnt_ee", 32'(EXECUTE_ENABLED), 1);
        chk("bnt_pc", ISSUE_PC, 32'h100);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 32'h104);
        #1 chk("bnt_stall", 32'(DEC_READY), 0);
        step;
        chk("bnt_ee_stall", 32'(EXECUTE_ENABLED), 0);
        step;
        RESOLVE_VALID = 1'b1;
        RESOLVE_TAKEN = 1'b0;
        #1 chk("bnt_res_rdy", 32'(DEC_READY), 0);
        step;
        RESOLVE_VALID = 1'b0;
        #1 chk("bnt_flush", 32'(FLUSH), 0);
        chk("bnt_resume", 32'(DEC_READY), 1);
        step;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bnt_ee1", 32'(EXECUTE_ENABLED), 1);
        chk("bnt_pc1", ISSUE_PC, 32'h104);
        wb(1, 0);
        step;
        step;
        wb(0, 0);

        // branch taken
        drv(1, 0, 0, 0, 0, 0, 0, 1, 32'h200);
        step;
        chk("bt_pc", ISSUE_PC, 32'h200);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 32'h204);
        step;
        RESOLVE_VALID = 1'b1;
        RESOLVE_TAKEN = 1'b1;
        #1 chk("bt_res_flush", 32'(FLUSH), 0);
        step;
        RESOLVE_VALID = 1'b0;
        RESOLVE_TAKEN = 1'b0;
        #1 chk("bt_flush", 32'(FLUSH), 1);
        chk("bt_flush_rdy", 32'(DEC_READY), 0);
        step;
        chk("bt_flush_end", 32'(FLUSH), 0);
        chk("bt_run_rdy", 32'(DEC_READY), 1);
        step;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bt_ee", 32'(EXECUTE_ENABLED), 1);
        chk("bt_pc1", ISSUE_PC, 32'h204);
        wb(1, 0);
        step;
        step;
        wb(0, 0);

        // set beats clear on x7
        drv(1, 0, 0, 7, 0, 0, 1, 0, 32'h300);
        step;
        drv(1, 0, 0, 7, 0, 0, 1, 0, 32'h304);
        wb(1, 7);
        #1 chk("waw_rel_rdy", 32'(DEC_READY), 1);
        step;
        wb(0, 0);
        drv(1, 0, 7, 0, 0, 1, 0, 0, 32'h308);
        #1 chk("sb7_stall", 32'(DEC_READY), 0);
        chk("sb7_haz", 32'(EXECUTE_HAZARD), 1);
        step;
        wb(1, 7);
        #1 chk("sb7_rel", 32'(DEC_READY), 1);
        step;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(1, 0);
        chk("sb7_pc", ISSUE_PC, 32'h308);
        step;
        wb(0, 0);

        // reset while waiting on a branch with three in flight
        drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h400);
        step;
        drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h404);
        step;
        drv(1, 0, 0, 0, 0, 0, 0, 1, 32'h408);
        step;
        chk("wr_pc", ISSUE_PC, 32'h408);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 32'h40c);
        #1 chk("wr_stall", 32'(DEC_READY), 0);
        RSTN = 1'b0;
        step;
        RSTN = 1'b1;
        chk("wr_rst_ee", 32'(EXECUTE_ENABLED), 0);
        chk("wr_rst_pc", ISSUE_PC, 0);
        chk("wr_rst_flush", 32'(FLUSH), 0);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h500);
        #1 chk("wr_rdy", 32'(DEC_READY), 1);
        step;
        chk("wr_ee", 32'(EXECUTE_ENABLED), 1);
        chk("wr_pc1", ISSUE_PC, 32'h500);
        for (int i = 1; i < 4; i++) begin
            drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h500 + 32'(4 * i));
            #1 chk("wr_infl_rdy", 32'(DEC_READY), 1);
            step;
        end
        drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h510);
        #1 chk("wr_infl_full", 32'(DEC_READY), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
